// File: rtl/acc9_pkg.sv
// Shared types and widths for the 9-bit accumulation stage.
package acc9_pkg;

  localparam int ACC_W = 9;

  typedef enum logic {ACCUM, DONE} acc9_state_t;

endpackage

// File: rtl/full_adder9.sv
// 9-bit ripple-carry adder used as the accumulator datapath.
module full_adder9
  import acc9_pkg::*;
(
  input  logic [ACC_W-1:0] A,
  input  logic [ACC_W-1:0] B,
  input  logic             Carryin,
  output logic [ACC_W-1:0] sum,
  output logic             Carryout
);

  logic [ACC_W:0] carry;

  // Explicit bit-level ripple so the carry chain matches the adder it models.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = Carryin;
    for (int i = 0; i < ACC_W; i++) begin
      sum[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Carryout = carry[ACC_W];

endmodule

// File: rtl/acc9_accumulator.sv
// Sums groups of N_SAMPLES 9-bit samples and presents the wrapped total
// with a sticky carry flag over a valid/ready result port.
module acc9_accumulator
  import acc9_pkg::*;
#(
  parameter int N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  acc9_state_t      state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W-1:0] sum;
  logic             cout;

  full_adder9 u_adder (
    .A        (acc),
    .B        (in_data),
    .Carryin  (1'b0),
    .sum      (sum),
    .Carryout (cout)
  );

  // in_ready is low in DONE, so an input accept and a result handshake never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= sum;
            ovf <= ovf | cout;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sum   = (state == DONE) ? acc : '0;
  assign out_ovf   = (state == DONE) ? ovf : 1'b0;

endmodule

// File: tb/tb_acc9_accumulator.sv
// Directed and randomized checks of acc9_accumulator for N_SAMPLES = 4 and 1
// against an arithmetic model of group sums and per-addition carries.
module tb_acc9_accumulator;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4;
  logic [8:0] in_data4, out_sum4;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
  logic [8:0] in_data1, out_sum1;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] IDLE = {1'b1, 1'b0, 1'b0, 9'd0};

  acc9_accumulator #(.N_SAMPLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_ovf(out_ovf4)
  );

  acc9_accumulator #(.N_SAMPLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_ovf(out_ovf1)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs4();
    return {in_ready4, out_valid4, out_ovf4, out_sum4};
  endfunction

  function automatic logic [11:0] obs1();
    return {in_ready1, out_valid1, out_ovf1, out_sum1};
  endfunction

  // Reference: plain running total, a carry whenever the 9-bit range is exceeded.
  function automatic void model(input int grp[4], output logic [8:0] s, output logic o);
    int total;
    total = 0;
    o = 1'b0;
    foreach (grp[i]) begin
      total += grp[i];
      if (total >= 512) begin
        o = 1'b1;
        total -= 512;
      end
    end
    s = 9'(total);
  endfunction

  // Vector layout: {in_ready, out_valid, out_ovf, out_sum[8:0]}.
  task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed rdy=%b vld=%b ovf=%b sum=%0d, expected rdy=%b vld=%b ovf=%b sum=%0d",
             tag, obs[11], obs[10], obs[9], obs[8:0], exp[11], exp[10], exp[9], exp[8:0]);
    end
  endtask

  task automatic applyStimulus(input int data);
    checkOutput("ready before accept", obs4(), IDLE);
    in_valid4 = 1'b1;
    in_data4  = 9'(data);
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic feed_group4(input int grp[4], input string tag, input bit bubbles,
                             output logic [8:0] exp_sum, output logic exp_ovf);
    int gaps;
    for (int i = 0; i < 4; i++) begin
      if (bubbles) begin
        gaps = int'($urandom_range(0, 2));
        repeat (gaps) begin
          in_valid4 = 1'b0;
          in_data4  = 9'($urandom);
          @(negedge clk);
          checkOutput({tag, " bubble"}, obs4(), IDLE);
        end
      end
      applyStimulus(grp[i]);
    end
    model(grp, exp_sum, exp_ovf);
    checkOutput({tag, " result"}, obs4(), {1'b0, 1'b1, exp_ovf, exp_sum});
  endtask

  task automatic release4(input string tag);
    out_ready4 = 1'b1;
    @(negedge clk);
    checkOutput({tag, " released"}, obs4(), IDLE);
  endtask

  initial begin
    int grp[4];
    logic [8:0] es;
    logic eo;
    int hold;

    rst = 1'b1;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset n4", obs4(), IDLE);
    checkOutput("reset n1", obs1(), IDLE);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic group");
    grp = '{10, 20, 30, 40};
    feed_group4(grp, "basic", 1'b0, es, eo);
    checkOutput("basic sum 100", obs4(), {1'b0, 1'b1, 1'b0, 9'd100});
    @(negedge clk);
    checkOutput("basic one cycle", obs4(), IDLE);

    $display("[TB] overflow");
    grp = '{500, 20, 0, 0};
    feed_group4(grp, "ovf", 1'b0, es, eo);
    checkOutput("ovf sum 8", obs4(), {1'b0, 1'b1, 1'b1, 9'd8});
    release4("ovf");
    grp = '{1, 1, 1, 1};
    feed_group4(grp, "ovf cleared", 1'b0, es, eo);
    checkOutput("ovf cleared sum 4", obs4(), {1'b0, 1'b1, 1'b0, 9'd4});
    release4("ovf cleared");

    $display("[TB] backpressure");
    out_ready4 = 1'b0;
    grp = '{100, 100, 100, 100};
    feed_group4(grp, "bp", 1'b0, es, eo);
    for (int i = 0; i < 5; i++) begin
      in_valid4 = 1'b1;
      in_data4  = 9'd7;
      @(negedge clk);
      checkOutput("bp hold 400", obs4(), {1'b0, 1'b1, 1'b0, 9'd400});
    end
    release4("bp");
    in_valid4 = 1'b0;
    grp = '{1, 2, 3, 4};
    feed_group4(grp, "bp next", 1'b0, es, eo);
    checkOutput("bp next sum 10", obs4(), {1'b0, 1'b1, 1'b0, 9'd10});
    release4("bp next");

    $display("[TB] bubbles");
    grp = '{3, 5, 7, 9};
    feed_group4(grp, "bubbles", 1'b1, es, eo);
    checkOutput("bubbles sum 24", obs4(), {1'b0, 1'b1, 1'b0, 9'd24});
    release4("bubbles");

    $display("[TB] reset mid-group");
    applyStimulus(50);
    applyStimulus(60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset n4", obs4(), IDLE);
    checkOutput("mid reset n1", obs1(), IDLE);
    grp = '{1, 2, 3, 4};
    feed_group4(grp, "after reset", 1'b0, es, eo);
    checkOutput("after reset sum 10", obs4(), {1'b0, 1'b1, 1'b0, 9'd10});
    release4("after reset");

    $display("[TB] randomized groups");
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 4; i++) grp[i] = int'($urandom_range(0, 511));
      out_ready4 = 1'b0;
      feed_group4(grp, "random", 1'b1, es, eo);
      hold = int'($urandom_range(0, 3));
      repeat (hold) begin
        @(negedge clk);
        checkOutput("random hold", obs4(), {1'b0, 1'b1, eo, es});
      end
      release4("random");
    end

    $display("[TB] N_SAMPLES = 1");
    checkOutput("n1 idle", obs1(), IDLE);
    in_valid1 = 1'b1;
    in_data1  = 9'd511;
    @(negedge clk);
    in_valid1 = 1'b0;
    checkOutput("n1 result 511", obs1(), {1'b0, 1'b1, 1'b0, 9'd511});
    @(negedge clk);
    checkOutput("n1 released", obs1(), IDLE);
    in_valid1 = 1'b1;
    in_data1  = 9'd2;
    @(negedge clk);
    in_valid1 = 1'b0;
    checkOutput("n1 result 2", obs1(), {1'b0, 1'b1, 1'b0, 9'd2});
    @(negedge clk);
    checkOutput("n1 final idle", obs1(), IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
